// File: rtl/riscv_v_reduct_accum_pkg.sv
// rtl/riscv_v_reduct_accum_pkg.sv - shared types and helpers for the vector bitwise reduction back end
package riscv_v_reduct_accum_pkg;

    localparam int RISCV_V_REDUCT_MAX_CHUNKS = 8;

    typedef enum logic [1:0] {
        REDUCT_OR  = 2'd0,
        REDUCT_AND = 2'd1,
        REDUCT_XOR = 2'd2
    } reduct_op_e;

    typedef enum logic [1:0] {
        OSIZE_8  = 2'd0,
        OSIZE_16 = 2'd1,
        OSIZE_32 = 2'd2,
        OSIZE_64 = 2'd3
    } osize_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } reduct_state_e;

    // Byte value that leaves any operand unchanged under op.
    function automatic logic [7:0] reduct_identity(reduct_op_e op);
        return (op == REDUCT_AND) ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [63:0] reduct_apply(reduct_op_e op, logic [63:0] a, logic [63:0] b);
        logic [63:0] r;
        case (op)
            REDUCT_AND: r = a & b;
            REDUCT_XOR: r = a ^ b;
            default:    r = a | b;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] osize_mask(osize_e osize);
        logic [63:0] m;
        case (osize)
            OSIZE_8:  m = 64'h0000_0000_0000_00FF;
            OSIZE_16: m = 64'h0000_0000_0000_FFFF;
            OSIZE_32: m = 64'h0000_0000_FFFF_FFFF;
            default:  m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/riscv_v_reduct_accum_if.sv
// rtl/riscv_v_reduct_accum_if.sv - start/chunk/result handshake bundle for the reduction accumulator
interface riscv_v_reduct_accum_if #(
    parameter int DATA_WIDTH = 128,
    parameter int CNT_W      = 4
);
    logic                    start_valid;
    logic                    start_ready;
    logic [1:0]              start_op;
    logic [1:0]              start_osize;
    logic [CNT_W-1:0]        start_num_chunks;
    logic [63:0]             start_seed;
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   in_data;
    logic [DATA_WIDTH/8-1:0] in_byte_valid;
    logic                    abort;
    logic                    out_valid;
    logic                    out_ready;
    logic [63:0]             out_data;

    modport master (
        output start_valid, start_op, start_osize, start_num_chunks, start_seed,
        output in_valid, in_data, in_byte_valid, abort, out_ready,
        input  start_ready, in_ready, out_valid, out_data
    );

    modport slave (
        input  start_valid, start_op, start_osize, start_num_chunks, start_seed,
        input  in_valid, in_data, in_byte_valid, abort, out_ready,
        output start_ready, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/riscv_v_reduct_fold.sv
// rtl/riscv_v_reduct_fold.sv - combinational fold of one masked chunk down to a single element
module riscv_v_reduct_fold
    import riscv_v_reduct_accum_pkg::*;
#(
    parameter int DATA_WIDTH = 128
) (
    input  reduct_op_e              op,
    input  osize_e                  osize,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [DATA_WIDTH/8-1:0] byte_valid,
    output logic [63:0]             result
);
    localparam int LANES = DATA_WIDTH / 64;

    logic [DATA_WIDTH-1:0] masked;
    logic [63:0]           lane_acc;
    logic [63:0]           w;

    always_comb begin
        masked = data;
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            if (!byte_valid[i]) masked[i*8 +: 8] = reduct_identity(op);
        end

        lane_acc = masked[63:0];
        for (int l = 1; l < LANES; l++) begin
            lane_acc = reduct_apply(op, lane_acc, masked[l*64 +: 64]);
        end

        // Halves are folded with the upper bits zeroed so the result stays zero-extended.
        w = lane_acc;
        if (osize < OSIZE_64) w = reduct_apply(op, {32'h0, w[63:32]}, {32'h0, w[31:0]});
        if (osize < OSIZE_32) w = reduct_apply(op, {48'h0, w[31:16]}, {48'h0, w[15:0]});
        if (osize < OSIZE_16) w = reduct_apply(op, {56'h0, w[15:8]},  {56'h0, w[7:0]});
        result = w & osize_mask(osize);
    end

endmodule

// File: rtl/riscv_v_reduct_accum.sv
// rtl/riscv_v_reduct_accum.sv - sequential OR/AND/XOR reduction over a stream of chunks into one scalar
module riscv_v_reduct_accum
    import riscv_v_reduct_accum_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int MAX_CHUNKS = RISCV_V_REDUCT_MAX_CHUNKS,
    parameter int CNT_W      = $clog2(MAX_CHUNKS) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    riscv_v_reduct_accum_if.slave  bus
);
    reduct_state_e    state, state_nxt;
    reduct_op_e       op_q, start_op_n;
    osize_e           osize_q;
    logic [CNT_W-1:0] num_q, cnt_q, num_sat;
    logic [63:0]      acc_q, fold_res;
    logic             start_fire, in_fire, out_fire, last_chunk;

    always_comb begin
        start_op_n = (bus.start_op == 2'd3) ? REDUCT_OR : reduct_op_e'(bus.start_op);
        num_sat    = (bus.start_num_chunks > CNT_W'(MAX_CHUNKS)) ? CNT_W'(MAX_CHUNKS)
                                                                 : bus.start_num_chunks;
        start_fire = (state == ST_IDLE)  && bus.start_valid;
        in_fire    = (state == ST_ACCUM) && bus.in_valid;
        out_fire   = (state == ST_DONE)  && bus.out_ready;
        last_chunk = (CNT_W'(cnt_q + CNT_W'(1)) == num_q);
    end

    riscv_v_reduct_fold #(.DATA_WIDTH(DATA_WIDTH)) u_fold (
        .op         (op_q),
        .osize      (osize_q),
        .data       (bus.in_data),
        .byte_valid (bus.in_byte_valid),
        .result     (fold_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_fire) state_nxt = (num_sat == '0) ? ST_DONE : ST_ACCUM;
            ST_ACCUM: if (in_fire && last_chunk) state_nxt = ST_DONE;
            ST_DONE:  if (out_fire) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (bus.abort) state_nxt = ST_IDLE;
    end

    always_comb begin
        bus.start_ready = (state == ST_IDLE);
        bus.in_ready    = (state == ST_ACCUM);
        bus.out_valid   = (state == ST_DONE);
        bus.out_data    = (state == ST_DONE) ? acc_q : 64'h0;
    end

    // abort wins over any handshake landing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= 64'h0;
            cnt_q   <= '0;
            num_q   <= '0;
            op_q    <= REDUCT_OR;
            osize_q <= OSIZE_8;
        end else if (bus.abort) begin
            acc_q <= 64'h0;
            cnt_q <= '0;
        end else if (start_fire) begin
            op_q    <= start_op_n;
            osize_q <= osize_e'(bus.start_osize);
            num_q   <= num_sat;
            acc_q   <= bus.start_seed & osize_mask(osize_e'(bus.start_osize));
            cnt_q   <= '0;
        end else if (in_fire) begin
            acc_q <= reduct_apply(op_q, acc_q, fold_res);
            cnt_q <= CNT_W'(cnt_q + CNT_W'(1));
        end
    end

endmodule
